limb_call_stack: RTL

Parametrised hardware call stack for the Limb CPU. It holds return program-counter values for `call`/`ret`, with the stack pointer kept internal and invisible to software. It generalises the fixed 8-bit internal stack to any PC width and depth, adds full/empty/count status and sticky overflow/underflow error flags, and offers a selectable overflow policy (reject or circular wrap). It sits beside the PC logic: the decoder drives `push` on `call` and `pop` on `ret`, and the PC mux reads `top`.

---
 rtl/limb_call_stack.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/limb_call_stack.sv
// limb_call_stack: return-address stack for the Limb CPU.
// Holds PC values pushed on call and popped on ret. The write pointer is
// internal; software only sees the top entry, the fill count and the sticky
// overflow/underflow flags. Depth need not be a power of two, so all pointer
// arithmetic wraps explicitly at DEPTH-1 rather than relying on bit width.
//
// Request handling per edge (highest priority first):
//   request              | action
//   ---------------------+-----------------------------------------------
//   reset_i              | empty stack, clear flags, ignore everything else
//   push & pop, count>0  | overwrite top in place, no error
//   push & pop, count=0  | acts as a plain push, flags underflow
//   push, not full       | store at wptr, advance wptr, count+1
//   push, full, no wrap  | drop the value, flag overflow
//   push, full, wrap     | overwrite oldest entry, advance wptr, flag overflow
//   pop, count>0         | retreat wptr, count-1
//   pop, count=0         | flag underflow only
module limb_call_stack #(
   parameter int ADDR_W           = 8,
   parameter int DEPTH            = 16,
   parameter bit WRAP_ON_OVERFLOW = 1'b0,
   localparam int CW              = $clog2(DEPTH + 1),
   localparam int PW              = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              push_i,
   input  logic [ADDR_W-1:0] push_data_i,
   input  logic              pop_i,
   input  logic              clear_err_i,
   output logic [ADDR_W-1:0] top_o,
   output logic [CW-1:0]     count_o,
   output logic              empty_o,
   output logic              full_o,
   output logic              overflow_o,
   output logic              underflow_o
);

   localparam logic [PW-1:0] PTR_LAST  = PW'(DEPTH - 1);
   localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);

   logic [ADDR_W-1:0] mem [DEPTH];

   logic [PW-1:0] wptr_q, wptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          overflow_q, overflow_d;
   logic          underflow_q, underflow_d;

   logic [PW-1:0] wptr_inc, wptr_dec;
   logic          empty_w, full_w;
   logic          mem_we;
   logic [PW-1:0] mem_waddr;
   logic          set_ovf, set_unf;

   assign wptr_inc = (wptr_q == PTR_LAST) ? '0 : wptr_q + PW'(1);
   assign wptr_dec = (wptr_q == '0) ? PTR_LAST : wptr_q - PW'(1);
   assign empty_w  = (count_q == '0);
   assign full_w   = (count_q == CNT_FULL);

   // Decode the request into next pointer/count, the storage write and flag sets.
   always_comb begin
      wptr_d    = wptr_q;
      count_d   = count_q;
      mem_we    = 1'b0;
      mem_waddr = wptr_q;
      set_ovf   = 1'b0;
      set_unf   = 1'b0;

      if (push_i && pop_i) begin
         if (!empty_w) begin
            mem_we    = 1'b1;
            mem_waddr = wptr_dec;
         end else begin
            mem_we    = 1'b1;
            mem_waddr = wptr_q;
            wptr_d    = wptr_inc;
            count_d   = CW'(1);
            set_unf   = 1'b1;
         end
      end else if (push_i) begin
         if (!full_w) begin
            mem_we    = 1'b1;
            mem_waddr = wptr_q;
            wptr_d    = wptr_inc;
            count_d   = count_q + CW'(1);
         end else begin
            set_ovf = 1'b1;
            if (WRAP_ON_OVERFLOW) begin
               mem_we    = 1'b1;
               mem_waddr = wptr_q;
               wptr_d    = wptr_inc;
            end
         end
      end else if (pop_i) begin
         if (!empty_w) begin
            wptr_d  = wptr_dec;
            count_d = count_q - CW'(1);
         end else begin
            set_unf = 1'b1;
         end
      end

      // A flag raised this edge beats a simultaneous clear.
      overflow_d  = set_ovf | (overflow_q  & ~clear_err_i);
      underflow_d = set_unf | (underflow_q & ~clear_err_i);
   end

   // Control state: pointer, fill count and sticky flags, synchronous reset.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wptr_q      <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wptr_q      <= wptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Entry storage is not reset; a write in a reset cycle is suppressed so the
   // lost push cannot resurface later.
   always_ff @(posedge clk_i) begin
      if (!reset_i && mem_we) begin
         mem[mem_waddr] <= push_data_i;
      end
   end

   // Zero-latency read of the current top; forced to 0 when nothing is stored.
   always_comb begin
      top_o = '0;
      if (!empty_w) begin
         top_o = mem[wptr_dec];
      end
   end

   assign count_o     = count_q;
   assign empty_o     = empty_w;
   assign full_o      = full_w;
   assign overflow_o  = overflow_q;
   assign underflow_o = underflow_q;

endmodule
